// File: rtl/sobel_pkg.sv
// Shared definitions for the sobel_stream edge detector: output mode encodings,
// datapath width helpers and the unsigned saturation used by every output mode.
package sobel_pkg;

    typedef enum logic [1:0] {
        MODE_MAG    = 2'd0,
        MODE_THRESH = 2'd1,
        MODE_GX     = 2'd2,
        MODE_GY     = 2'd3
    } mode_e;

    // Each gradient spans +/-4*(2^PIX_W-1); |gx|+|gy| needs one bit more.
    function automatic int grad_w(input int pix_w);
        return pix_w + 3;
    endfunction

    function automatic int mag_w(input int pix_w);
        return pix_w + 4;
    endfunction

    function automatic logic [31:0] saturate(input logic [31:0] value, input int pix_w);
        logic [31:0] max_v;
        max_v = (32'd1 << pix_w) - 32'd1;
        return (value > max_v) ? max_v : value;
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Enable-gated delay line: data_o is the sample written DEPTH enabled cycles ago,
// read combinationally so it lines up with the sample being written now.
module sobel_line_buffer #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    assign data_o = mem_q[ptr_q];

    always_comb begin
        // NOTE: the default-first assignment keeps this block free of inferred latches.
        ptr_d = ptr_q;
        if (en_i) begin
            ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // NOTE: storage is deliberately not reset; stale contents never reach an emitted result.
    always_ff @(posedge clock) begin
        if (en_i) begin
            mem_q[ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector with two line buffers, a two-stage pipeline
// (gradients, then output select) and interior-only emission with an end-of-frame flag.
module sobel_stream #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [PIX_W-1:0] in_pixel,
    input  logic [1:0]       mode,
    input  logic [PIX_W-1:0] threshold,
    output logic             out_valid,
    output logic [PIX_W-1:0] out_pixel,
    output logic             out_eof
);

    import sobel_pkg::*;

    localparam int GRAD_W = grad_w(PIX_W);
    localparam int MAG_W  = mag_w(PIX_W);
    localparam int COL_W  = $clog2(IMG_W);
    localparam int ROW_W  = $clog2(IMG_H);

    // ---------------- raster position ----------------
    logic [COL_W-1:0] col_q, col_d, pos_col;
    logic [ROW_W-1:0] row_q, row_d, pos_row;
    logic             last_col, last_row, interior, frame_end;

    always_comb begin
        pos_col   = in_sof ? '0 : col_q;
        pos_row   = in_sof ? '0 : row_q;
        last_col  = (pos_col == COL_W'(IMG_W - 1));
        last_row  = (pos_row == ROW_W'(IMG_H - 1));
        // The window is spatially whole only once two full columns and rows sit behind it.
        interior  = (pos_col >= COL_W'(2)) && (pos_row >= ROW_W'(2));
        frame_end = last_col && last_row;
        col_d     = col_q;
        row_d     = row_q;
        if (in_valid) begin
            col_d = last_col ? '0 : pos_col + COL_W'(1);
            if (last_col) begin
                row_d = last_row ? '0 : pos_row + ROW_W'(1);
            end else begin
                row_d = pos_row;
            end
        end
    end

    // ---------------- line buffers and window ----------------
    logic [PIX_W-1:0] line1_out, line2_out;

    sobel_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_line1 (
        .clock  (clock),
        .rst_n  (rst_n),
        .en_i   (in_valid),
        .data_i (in_pixel),
        .data_o (line1_out)
    );

    sobel_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_line2 (
        .clock  (clock),
        .rst_n  (rst_n),
        .en_i   (in_valid),
        .data_i (line1_out),
        .data_o (line2_out)
    );

    // Index 0 holds column c-2, index 1 column c-1; column c comes live from the buffers.
    logic [PIX_W-1:0] top_q [2];
    logic [PIX_W-1:0] mid_q [2];
    logic [PIX_W-1:0] bot_q [2];

    always_ff @(posedge clock) begin
        if (in_valid) begin
            top_q[0] <= top_q[1];
            top_q[1] <= line2_out;
            mid_q[0] <= mid_q[1];
            mid_q[1] <= line1_out;
            bot_q[0] <= bot_q[1];
            bot_q[1] <= in_pixel;
        end
    end

    // ---------------- stage 1: gradients ----------------
    function automatic logic signed [GRAD_W-1:0] ext(input logic [PIX_W-1:0] pix);
        return $signed({3'b000, pix});
    endfunction

    logic signed [GRAD_W-1:0] p1, p2, p3, p4, p6, p7, p8, p9;
    logic signed [GRAD_W-1:0] gx_d, gy_d;

    always_comb begin
        p1   = ext(top_q[0]);
        p2   = ext(top_q[1]);
        p3   = ext(line2_out);
        p4   = ext(mid_q[0]);
        p6   = ext(line1_out);
        p7   = ext(bot_q[0]);
        p8   = ext(bot_q[1]);
        p9   = ext(in_pixel);
        gx_d = (p3 + (p6 <<< 1) + p9) - (p1 + (p4 <<< 1) + p7);
        gy_d = (p7 + (p8 <<< 1) + p9) - (p1 + (p2 <<< 1) + p3);
    end

    logic                     v1_q, eof1_q;
    logic signed [GRAD_W-1:0] gx_q, gy_q;
    mode_e                    mode_q;
    logic [PIX_W-1:0]         thr_q;

    always_ff @(posedge clock) begin
        if (in_valid) begin
            gx_q   <= gx_d;
            gy_q   <= gy_d;
            mode_q <= mode_e'(mode);
            thr_q  <= threshold;
        end
    end

    // ---------------- stage 2: output select ----------------
    logic [GRAD_W-1:0] abs_gx, abs_gy;
    logic [MAG_W-1:0]  mag;
    logic [PIX_W-1:0]  sat_mag, result_d;

    always_comb begin
        abs_gx  = gx_q[GRAD_W-1] ? $unsigned(-gx_q) : $unsigned(gx_q);
        abs_gy  = gy_q[GRAD_W-1] ? $unsigned(-gy_q) : $unsigned(gy_q);
        mag     = {1'b0, abs_gx} + {1'b0, abs_gy};
        sat_mag = PIX_W'(saturate(32'(mag), PIX_W));
        case (mode_q)
            MODE_MAG:    result_d = sat_mag;
            MODE_THRESH: result_d = (sat_mag > thr_q) ? '1 : '0;
            MODE_GX:     result_d = PIX_W'(saturate(32'(abs_gx), PIX_W));
            MODE_GY:     result_d = PIX_W'(saturate(32'(abs_gy), PIX_W));
            default:     result_d = sat_mag;
        endcase
    end

    // ---------------- control registers ----------------
    logic             out_valid_q, out_eof_q;
    logic [PIX_W-1:0] out_pixel_q;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            v1_q        <= 1'b0;
            eof1_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_eof_q   <= 1'b0;
            out_pixel_q <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            v1_q        <= in_valid && interior;
            eof1_q      <= in_valid && interior && frame_end;
            out_valid_q <= v1_q;
            out_eof_q   <= v1_q && eof1_q;
            if (v1_q) begin
                out_pixel_q <= result_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_eof   = out_eof_q;
    assign out_pixel = out_pixel_q;

endmodule

// File: doc/sobel_stream.md
Name: sobel_stream

Overview:
- Parametrised streaming 3x3 Sobel edge detector; successor to the single-pixel-delay filter.
- Uses true line buffers, so the 3x3 window is spatially correct for an IMG_W x IMG_H raster.
- Signed gradient arithmetic with saturation, selectable output mode and a valid/frame-marker stream interface.
- Sits between the pixel source (camera/decoder) and the downstream framebuffer or edge consumer.

Parameters:
- PIX_W, 8, pixel bit width (unsigned greyscale).
- IMG_W, 640, pixels per line (min 4).
- IMG_H, 480, lines per frame (min 3).

Ports:
- clock  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_pixel valid this cycle; no backpressure.
- in_sof  in  1  marks the first pixel of a frame; qualified by in_valid.
- in_pixel  in  PIX_W  raster-order pixel.
- mode  in  2  0=|gx|+|gy|, 1=threshold, 2=|gx|, 3=|gy|; sampled with each accepted pixel.
- threshold  in  PIX_W  edge threshold for mode 1.
- out_valid  out  1  out_pixel valid.
- out_pixel  out  PIX_W  result for one interior pixel.
- out_eof  out  1  high with the last output pixel of a frame.

Behaviour:
- Reset (async assert, sync deassert by the system):
  - out_valid, out_eof, out_pixel go to 0.
  - col/row counters go to 0.
  - Pipeline valid bits are cleared.
  - Line-buffer contents are don't-care.
- Counters:
  - col advances 0..IMG_W-1 per accepted pixel and wraps to 0, incrementing row.
  - row wraps IMG_H-1 -> 0, so back-to-back frames need no in_sof.
  - in_valid && in_sof forces this pixel to (row 0, col 0) at any time, including mid-frame.
- Line buffers:
  - Two IMG_W-deep delay lines advance only on in_valid.
  - A 3x3 window register shifts in {line2 out, line1 out, in_pixel} on in_valid.
  - Window p1..p9 is row-major, p1 top-left, p9 = current input.
- Gradients (signed, PIX_W+3 bits):
  - gx = (p3+2p6+p9) - (p1+2p4+p7).
  - gy = (p7+2p8+p9) - (p1+2p2+p3).
- Output value:
  - mag = |gx|+|gy|, PIX_W+4 bits; max 8*(2^PIX_W-1), no overflow.
  - Mode 0: mag saturated to 2^PIX_W-1.
  - Mode 2: |gx| saturated to 2^PIX_W-1.
  - Mode 3: |gy| saturated to 2^PIX_W-1.
  - Mode 1: all-ones if saturated mag > threshold (strict), else 0.
- Output set: only interior centres are emitted, i.e. centre (r,c) with 1<=r<=IMG_H-2 and 1<=c<=IMG_W-2. That is (IMG_W-2)*(IMG_H-2) outputs per frame, raster order; border pixels are never emitted.
- Timing:
  - Centre (r,c) becomes computable when input (r+1,c+1) is accepted.
  - Stage 1 registers gx/gy; stage 2 registers out_pixel.
  - out_valid asserts exactly 2 clocks after that input's accept cycle.
  - Pipeline advances every clock, independent of in_valid; gaps in in_valid produce matching gaps in out_valid.
- The window must not combine pixels across a line wrap; such positions fall outside the interior set and are suppressed.
- out_eof asserts with centre (IMG_H-2, IMG_W-2) only.
- in_sof mid-frame:
  - Results already in flight still emerge.
  - No output is produced until row 2 of the new frame.
- Reset mid-frame:
  - In-flight results are discarded.
  - The first input after reset is treated as (0,0) regardless of in_sof.

Decomposition:
- Shared package sobel_pkg holds:
  - mode encodings MODE_MAG, MODE_THRESH, MODE_GX, MODE_GY;
  - width constants GRAD_W = PIX_W+3 and MAG_W = PIX_W+4 (as functions of PIX_W);
  - a saturate function.
- One sub-module, sobel_line_buffer: parametrised depth/width delay line with an enable, instantiated twice.

Test Plan (IMG_W=8, IMG_H=6, PIX_W=8 unless stated):
- Uniform frame of 100, mode 0 -> exactly 24 outputs, all 0; out_eof only on the 24th; each out_valid 2 clocks after its triggering input.
- Vertical step (cols 0-3 = 10, cols 4-7 = 20), mode 0 -> cols 3 and 4 give 40, other cols 0; mode 2 gives the same; mode 3 gives all 0.
- Vertical step 0/255, mode 0 -> cols 3,4 saturate to 255 (raw 1020); mode 1, threshold 254 -> 255 at cols 3,4, else 0; threshold 255 -> all 0.
- Horizontal step (rows 0-2 = 0, rows 3-5 = 50), mode 3 -> rows 2 and 3 give 200, other rows 0; mode 2 gives all 0.
- Random in_valid gaps (~50% duty) on the step image -> same output values/order as gap-free; each out_valid exactly 2 clocks after its trigger input.
- Two frames: assert in_sof at (row 3, col 2) of the first, then start the second -> 24 correct outputs for the second frame.
- Separate run: assert rst_n low mid-frame -> out_valid drops immediately, and the next full frame yields 24 correct outputs.
